// File: rtl/param_cunit.sv
// param_cunit: Moore-style control unit for the LabB single-cycle datapath.
// Fetches from a synchronous instruction ROM (one cycle of read latency),
// decodes through a small FSM and drives data RAM, register file and ALU
// select lines. Register, data-address and PC widths are parameters.
// StateO exposes the FSM state code so external checkers can follow it.
module param_cunit #(
    parameter int RAW = 4,
    parameter int DAW = 8,
    parameter int PCW = 7,
    localparam int IW = 4 + 3 * RAW
) (
    input  logic           Clock,
    input  logic           Reset,
    input  logic [IW-1:0]  I_data,
    input  logic           Alu_Z,
    output logic [PCW-1:0] PC_Out,
    output logic [IW-1:0]  IR_Out,
    output logic [3:0]     StateO,
    output logic [DAW-1:0] D_addr,
    output logic           D_wr,
    output logic           RF_s,
    output logic [RAW-1:0] RF_W_addr,
    output logic           RF_W_wr,
    output logic [RAW-1:0] RF_Ra_addr,
    output logic           RF_Ra_rd,
    output logic [RAW-1:0] RF_Rb_addr,
    output logic           RF_Rb_rd,
    output logic [2:0]     Alu_s0
);

    localparam logic [3:0] S_INIT   = 4'd0;
    localparam logic [3:0] S_FETCH  = 4'd1;
    localparam logic [3:0] S_DECODE = 4'd2;
    localparam logic [3:0] S_NOOP   = 4'd3;
    localparam logic [3:0] S_LOAD_A = 4'd4;
    localparam logic [3:0] S_LOAD_B = 4'd5;
    localparam logic [3:0] S_STORE  = 4'd6;
    localparam logic [3:0] S_ADD    = 4'd7;
    localparam logic [3:0] S_SUB    = 4'd8;
    localparam logic [3:0] S_HALT   = 4'd9;
    localparam logic [3:0] S_JUMP   = 4'd10;

    logic [3:0]     state;
    logic [PCW-1:0] pc;
    logic [IW-1:0]  ir;

    // Instruction fields, always taken from the instruction register.
    logic [3:0]     op;
    logic [RAW-1:0] fa;
    logic [RAW-1:0] fb;
    logic [RAW-1:0] fc;
    logic [DAW-1:0] faddr;
    logic [PCW-1:0] ftgt;

    assign op    = ir[IW-1 -: 4];
    assign fa    = ir[3*RAW-1 -: RAW];
    assign fb    = ir[2*RAW-1 -: RAW];
    assign fc    = ir[RAW-1:0];
    assign faddr = ir[DAW-1:0];
    assign ftgt  = ir[PCW-1:0];

    assign PC_Out = pc;
    assign IR_Out = ir;
    assign StateO = state;

    // State, PC and IR sequencing; reset clears everything asynchronously.
    // The PC increments in FETCH and may be overwritten by a jump target on
    // leaving DECODE; the JUMP bubble then gives the ROM a cycle to settle.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= S_INIT;
            pc    <= '0;
            ir    <= '0;
        end else begin
            case (state)
                S_INIT:   state <= S_FETCH;
                S_FETCH: begin
                    ir    <= I_data;
                    pc    <= pc + PCW'(1);
                    state <= S_DECODE;
                end
                S_DECODE: begin
                    case (op)
                        4'd1:    state <= S_LOAD_A;
                        4'd2:    state <= S_STORE;
                        4'd3:    state <= S_ADD;
                        4'd4:    state <= S_SUB;
                        4'd5:    state <= S_HALT;
                        4'd6:    state <= S_JUMP;
                        4'd7:    state <= S_JUMP;
                        default: state <= S_NOOP;
                    endcase
                    if (op == 4'd6 || (op == 4'd7 && Alu_Z))
                        pc <= ftgt;
                end
                S_LOAD_A: state <= S_LOAD_B;
                S_HALT:   state <= S_HALT;
                default:  state <= S_FETCH;
            endcase
        end
    end

    // Control outputs decoded from state and IR; anything not driven is 0.
    always_comb begin
        D_addr     = '0;
        D_wr       = 1'b0;
        RF_s       = 1'b0;
        RF_W_addr  = '0;
        RF_W_wr    = 1'b0;
        RF_Ra_addr = '0;
        RF_Ra_rd   = 1'b0;
        RF_Rb_addr = '0;
        RF_Rb_rd   = 1'b0;
        Alu_s0     = 3'b000;
        case (state)
            S_LOAD_A: begin
                D_addr = faddr;
            end
            S_LOAD_B: begin
                D_addr    = faddr;
                RF_s      = 1'b1;
                RF_W_addr = fa;
                RF_W_wr   = 1'b1;
            end
            S_STORE: begin
                D_addr     = faddr;
                D_wr       = 1'b1;
                RF_Ra_addr = fa;
                RF_Ra_rd   = 1'b1;
            end
            S_ADD, S_SUB: begin
                RF_Ra_addr = fb;
                RF_Ra_rd   = 1'b1;
                RF_Rb_addr = fc;
                RF_Rb_rd   = 1'b1;
                RF_W_addr  = fa;
                RF_W_wr    = 1'b1;
                Alu_s0     = (state == S_ADD) ? 3'b001 : 3'b010;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_param_cunit.sv
// tb_param_cunit: self-checking bench for param_cunit with default widths.
// An instruction-level model expands each ROM word into its expected
// per-cycle state/PC/IR/control pattern; outputs are checked on the
// falling edge, and inputs are driven there too.
module tb_param_cunit;

    localparam int RAW = 4;
    localparam int DAW = 8;
    localparam int PCW = 7;
    localparam int IW  = 4 + 3 * RAW;
    localparam int CW  = DAW + 2 + 3 * RAW + 3 + 3;

    logic           clk;
    logic           rst;
    logic [IW-1:0]  i_data;
    logic           alu_z;
    logic [PCW-1:0] pc_out;
    logic [IW-1:0]  ir_out;
    logic [3:0]     state_o;
    logic [DAW-1:0] d_addr;
    logic           d_wr;
    logic           rf_s;
    logic [RAW-1:0] rf_w_addr;
    logic           rf_w_wr;
    logic [RAW-1:0] rf_ra_addr;
    logic           rf_ra_rd;
    logic [RAW-1:0] rf_rb_addr;
    logic           rf_rb_rd;
    logic [2:0]     alu_s0;

    logic [IW-1:0]  rom [0:(1<<PCW)-1];
    logic [PCW-1:0] mpc;
    logic [IW-1:0]  mir;
    int             z_sel;
    int             n_cmp;
    int             n_bad;

    param_cunit #(.RAW(RAW), .DAW(DAW), .PCW(PCW)) dut (
        .Clock(clk), .Reset(rst), .I_data(i_data), .Alu_Z(alu_z),
        .PC_Out(pc_out), .IR_Out(ir_out), .StateO(state_o),
        .D_addr(d_addr), .D_wr(d_wr), .RF_s(rf_s),
        .RF_W_addr(rf_w_addr), .RF_W_wr(rf_w_wr),
        .RF_Ra_addr(rf_ra_addr), .RF_Ra_rd(rf_ra_rd),
        .RF_Rb_addr(rf_rb_addr), .RF_Rb_rd(rf_rb_rd),
        .Alu_s0(alu_s0)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // synchronous instruction ROM, one cycle of latency
    always @(posedge clk) i_data <= rom[pc_out];

    function automatic logic [CW-1:0] pack(
        input logic [DAW-1:0] da, input logic dw, input logic s,
        input logic [RAW-1:0] wa, input logic ww,
        input logic [RAW-1:0] ra, input logic rr,
        input logic [RAW-1:0] rb, input logic br, input logic [2:0] al);
        return {da, dw, s, wa, ww, ra, rr, rb, br, al};
    endfunction

    function automatic logic [CW-1:0] obs_ctl();
        return pack(d_addr, d_wr, rf_s, rf_w_addr, rf_w_wr,
                    rf_ra_addr, rf_ra_rd, rf_rb_addr, rf_rb_rd, alu_s0);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle: check at the falling edge, then drive Alu_Z for the next edge.
    task automatic cyc(input logic [3:0] es, input logic [PCW-1:0] ep,
                       input logic [IW-1:0] eir, input logic [CW-1:0] ectl);
        @(negedge clk);
        chk("state", 32'(state_o), 32'(es));
        chk("pc", 32'(pc_out), 32'(ep));
        chk("ir", 32'(ir_out), 32'(eir));
        chk("ctl", 32'(obs_ctl()), 32'(ectl));
        alu_z = (z_sel == 2) ? 1'($urandom_range(0, 1)) : z_sel[0];
    endtask

    task automatic check_init();
        chk("init_state", 32'(state_o), 32'd0);
        chk("init_pc", 32'(pc_out), 32'd0);
        chk("init_ir", 32'(ir_out), 32'd0);
        chk("init_ctl", 32'(obs_ctl()), 32'd0);
    endtask

    // Instruction-level reference: executes n instructions from the ROM image.
    task automatic run_instr(input int n);
        logic [IW-1:0]  instr;
        logic [3:0]     op;
        logic [RAW-1:0] a, b, c;
        logic [DAW-1:0] addr;
        logic [PCW-1:0] tgt;
        logic           z;
        for (int k = 0; k < n; k++) begin
            cyc(4'd1, mpc, mir, '0);
            instr = rom[mpc];
            mpc   = mpc + 1'b1;
            mir   = instr;
            cyc(4'd2, mpc, mir, '0);
            z    = alu_z;
            op   = instr[IW-1 -: 4];
            a    = instr[3*RAW-1 -: RAW];
            b    = instr[2*RAW-1 -: RAW];
            c    = instr[RAW-1:0];
            addr = instr[DAW-1:0];
            tgt  = instr[PCW-1:0];
            case (op)
                4'd1: begin
                    cyc(4'd4, mpc, mir, pack(addr, 0, 0, '0, 0, '0, 0, '0, 0, 3'b000));
                    cyc(4'd5, mpc, mir, pack(addr, 0, 1, a, 1, '0, 0, '0, 0, 3'b000));
                end
                4'd2: cyc(4'd6, mpc, mir, pack(addr, 1, 0, '0, 0, a, 1, '0, 0, 3'b000));
                4'd3: cyc(4'd7, mpc, mir, pack('0, 0, 0, a, 1, b, 1, c, 1, 3'b001));
                4'd4: cyc(4'd8, mpc, mir, pack('0, 0, 0, a, 1, b, 1, c, 1, 3'b010));
                4'd5: begin
                    for (int h = 0; h < 20; h++) cyc(4'd9, mpc, mir, '0);
                    return;
                end
                4'd6: begin
                    mpc = tgt;
                    cyc(4'd10, mpc, mir, '0);
                end
                4'd7: begin
                    if (z) mpc = tgt;
                    cyc(4'd10, mpc, mir, '0);
                end
                default: cyc(4'd3, mpc, mir, '0);
            endcase
        end
    endtask

    initial begin
        logic [3:0] rop;
        n_cmp = 0;
        n_bad = 0;
        z_sel = 0;
        alu_z = 1'b0;
        rst   = 1'b1;
        for (int i = 0; i < (1 << PCW); i++) rom[i] = '0;
        rom[7'h00] = 16'h132A;
        rom[7'h01] = 16'h232B;
        rom[7'h02] = 16'h3512;
        rom[7'h03] = 16'h4512;
        rom[7'h04] = 16'h0000;
        rom[7'h05] = 16'h7010;
        rom[7'h06] = 16'hF123;
        rom[7'h07] = 16'h6040;
        rom[7'h40] = 16'h607F;
        rom[7'h7F] = 16'h0000;
        rom[7'h10] = 16'h5000;

        // reset pulse, then directed program
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_init();
        rst = 1'b0;
        mpc = '0;
        mir = '0;
        #1 check_init();
        run_instr(10);   // JZ at 0x05 not taken, JMP chain, wrap from 0x7F
        z_sel = 1;
        run_instr(7);    // JZ at 0x05 taken to 0x10, HALT

        // reset from HALT takes effect without a clock edge
        #2 rst = 1'b1;
        #1 check_init();

        // reset aborts an in-flight LOAD_B
        @(negedge clk);
        rst = 1'b0;
        mpc = '0;
        mir = '0;
        #1 check_init();
        cyc(4'd1, 7'h00, 16'h0000, '0);
        cyc(4'd2, 7'h01, 16'h132A, '0);
        cyc(4'd4, 7'h01, 16'h132A, pack(8'h2A, 0, 0, '0, 0, '0, 0, '0, 0, 3'b000));
        cyc(4'd5, 7'h01, 16'h132A, pack(8'h2A, 0, 1, 4'd3, 1, '0, 0, '0, 0, 3'b000));
        #2 rst = 1'b1;
        #1 chk("abort_wr", 32'(rf_w_wr), 32'd0);
        check_init();

        // randomized program, no HALT, random Alu_Z
        for (int i = 0; i < (1 << PCW); i++) begin
            do rop = 4'($urandom_range(0, 15)); while (rop == 4'd5);
            rom[i] = {rop, 12'($urandom)};
        end
        @(negedge clk);
        rst   = 1'b0;
        mpc   = '0;
        mir   = '0;
        z_sel = 2;
        #1 check_init();
        run_instr(400);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
